// File: rtl/opl3_pkg.sv
// Shared types and mgmt register map for the OPL3 host write queue.
package opl3_pkg;

   typedef struct packed {
      logic       bank;
      logic [7:0] reg_idx;
      logic [7:0] data;
   } opl3_wr_entry_t;

   localparam logic [7:0]  MGMT_STATUS = 8'h00;
   localparam logic [7:0]  MGMT_POP    = 8'h01;
   localparam logic [7:0]  MGMT_PEEK   = 8'h02;
   localparam logic [15:0] EMPTY_WORD  = 16'hFFFF;

   // Bank-0 timer registers are handled by local timer logic, never by the synth.
   function automatic logic is_timer_reg(input logic [8:0] idx);
      return (idx >= 9'h002) && (idx <= 9'h004);
   endfunction

endpackage

// File: rtl/opl3_queue_ram.sv
// Simple dual-port entry store with a registered read port; a same-cycle write to
// the read address is forwarded so the show-ahead head never goes stale.
module opl3_queue_ram
   import opl3_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic           clk,
   input  logic           we,
   input  logic [AW-1:0]  waddr,
   input  opl3_wr_entry_t wdata,
   input  logic [AW-1:0]  raddr,
   output opl3_wr_entry_t rdata
);

   opl3_wr_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
   end

endmodule

// File: rtl/opl3_write_queue.sv
// OPL3 host port capture: index latch plus data writes queued as {bank,reg,data}
// entries, drained by the synth through a registered 16-bit mgmt read port.
module opl3_write_queue
   import opl3_pkg::*;
#(
   parameter int DEPTH         = 256,
   parameter int FILTER_TIMERS = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic [7:0]  din,
   input  logic        wr,
   input  logic [7:0]  mgmt_address,
   input  logic        mgmt_read,
   output logic [15:0] mgmt_readdata,
   output logic        overflow,
   output logic        not_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [8:0]     index;
   logic [AW-1:0]  wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [10:0]    level;
   logic           empty, full, push_req, push_ok, pop, drop, status_rd;
   logic [15:0]    rd_word;
   opl3_wr_entry_t head, wentry;

   // Read address runs one step ahead so back-to-back POPs see consecutive entries.
   opl3_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr),
      .wdata (wentry),
      .raddr (rd_ptr_nxt),
      .rdata (head)
   );

   always_comb begin
      empty      = (level == '0);
      full       = (level == 11'(DEPTH));
      push_req   = wr && addr[0] && !((FILTER_TIMERS != 0) && is_timer_reg(index));
      pop        = mgmt_read && (mgmt_address == MGMT_POP) && !empty;
      push_ok    = push_req && (!full || pop);
      drop       = push_req && !push_ok;
      status_rd  = mgmt_read && (mgmt_address == MGMT_STATUS);
      rd_ptr_nxt = reset ? '0 : rd_ptr + AW'(pop);
      wentry     = '{bank: index[8], reg_idx: index[7:0], data: din};
      not_empty  = !empty;

      rd_word = 16'h0000;
      case (mgmt_address)
         MGMT_STATUS: rd_word = {!empty, overflow, (!empty && head.bank), 2'b00, level};
         MGMT_POP,
         MGMT_PEEK:   rd_word = empty ? EMPTY_WORD : {head.reg_idx, head.data};
         default:     rd_word = 16'h0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         index         <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         level         <= '0;
         overflow      <= 1'b0;
         mgmt_readdata <= '0;
      end else begin
         if (wr && !addr[0]) index <= {addr[1], din};
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_nxt;
         level  <= level + 11'(push_ok) - 11'(pop);
         // A drop in the same cycle as a STATUS read keeps the flag set.
         if (drop)           overflow <= 1'b1;
         else if (status_rd) overflow <= 1'b0;
         if (mgmt_read) mgmt_readdata <= rd_word;
      end
   end

endmodule
